// File: rtl/btn_pkg.sv
// Shared types and helpers for the button event generator.
// The counter width is derived from whichever period is longer.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESSED,
        BTN_HELD
    } btn_state_e;

    function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
        int m;
        m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registers a clean level and flags its rising and falling edges.
// Reset preloads the register from the input, so a level already present at reset is not an edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_a,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    // During reset the register still follows the input, which is what makes the preload work.
    always_ff @(posedge clk) begin
        r_q <= i_a;
    end

    assign o_rise = i_a & ~r_q & ~rst;
    assign o_fall = ~i_a & r_q & ~rst;

endmodule

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press/release/long-press/auto-repeat strobes
// plus a registered held level. Every output comes straight from a flop.
module btn_event_gen
    import btn_pkg::*;
#(
    parameter logic ACTIVE_LEVEL  = 1'b1,
    parameter int   LONG_CYCLES   = 25_000_000,
    parameter int   REPEAT_CYCLES = 5_000_000,
    parameter logic REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_a;
    logic             w_rise;
    logic             w_fall;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_long_nxt;
    logic             w_rep_nxt;
    logic             w_held_nxt;

    assign w_a = (i_d == ACTIVE_LEVEL);

    edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .i_a    (w_a),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= BTN_IDLE;
            r_cnt     <= '0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
            o_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            o_press   <= w_press_nxt;
            o_release <= w_release_nxt;
            o_long    <= w_long_nxt;
            o_repeat  <= w_rep_nxt;
            o_held    <= w_held_nxt;
        end
    end

    // Release wins over any terminal count landing on the same edge, suppressing that strobe.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_rep_nxt     = 1'b0;

        if (w_fall) begin
            w_release_nxt = 1'b1;
            w_state_nxt   = BTN_IDLE;
            w_cnt_nxt     = '0;
        end else if (w_rise) begin
            w_press_nxt = 1'b1;
            w_state_nxt = BTN_PRESSED;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                BTN_PRESSED: begin
                    if (r_cnt == LONG_TC) begin
                        w_long_nxt  = 1'b1;
                        w_state_nxt = BTN_HELD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                BTN_HELD: begin
                    if (REPEAT_EN) begin
                        if (r_cnt == REPEAT_TC) begin
                            w_rep_nxt = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = BTN_IDLE;
                end
            endcase
        end

        w_held_nxt = (w_state_nxt != BTN_IDLE);
    end

endmodule

// File: doc/btn_event_gen.md
Name: btn_event_gen

Overview:
- Sits directly downstream of the debouncer and consumes its clean level output `q`.
- Converts that level into single-cycle event strobes for the rest of the myMIPS board logic (single-step, mode select): press, release, long-press and auto-repeat.
- Also exports a registered "held" level.
- One clock domain: 25 MHz board clock.

Parameters:
- ACTIVE_LEVEL, 1'b1: input level that means "pressed"; matches the debouncer's non-default level.
- LONG_CYCLES, 25_000_000: cycles from press strobe to long-press strobe (1 s at 25 MHz); legal range >= 2.
- REPEAT_CYCLES, 5_000_000: period of auto-repeat strobes after long-press; legal range >= 1.
- REPEAT_EN, 1'b1: 1 = generate o_repeat while held; 0 = o_repeat tied low.
- CNT_W, $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1): counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_d  in  1  debounced button level (debouncer q).
- o_press  out  1  one-cycle strobe on press.
- o_release  out  1  one-cycle strobe on release.
- o_long  out  1  one-cycle strobe when held LONG_CYCLES.
- o_repeat  out  1  one-cycle strobe every REPEAT_CYCLES after o_long.
- o_held  out  1  level, high while the FSM is not IDLE.

Behaviour:
- Define a = (i_d == ACTIVE_LEVEL). a_q is the registered copy of a.
- Reset (rst=1 at a clk edge):
  - state=IDLE, cnt=0, all outputs 0.
  - a_q loads the current a, so a button already held at reset release produces no o_press.
  - An active level at reset release is ignored until it goes inactive and returns.
- All outputs are registered; none is combinational from i_d.
- Press detection:
  - At edge k with a=1 and a_q=0, o_press=1 for the cycle after edge k, i.e. latency 1.
  - At the same edge: state -> PRESSED, o_held -> 1.
- Release detection:
  - At any edge with a=0 and a_q=1, o_release=1 for one cycle.
  - At the same edge: state -> IDLE, cnt -> 0, o_held -> 0.
- FSM states:
  - IDLE: waits for press.
  - PRESSED: cnt counts up each cycle. o_long is asserted exactly LONG_CYCLES cycles after o_press was asserted; at that edge state -> HELD and cnt -> 0.
  - HELD: o_repeat is asserted REPEAT_CYCLES cycles after o_long, then every REPEAT_CYCLES cycles, until release. With REPEAT_EN=0, HELD only waits for release.
- Priority at one edge: rst > release > long/repeat.
  - A release coinciding with the long or repeat terminal count suppresses that strobe.
- At most one of o_press/o_release/o_long/o_repeat is high in any cycle.
  - Exception: with REPEAT_CYCLES=1, o_repeat is high every cycle in HELD.
- Counter never wraps: it is cleared on every state change and on each repeat strobe.
- A glitch in i_d shorter than 1 cycle is not possible, since i_d comes from the debouncer. A 1-cycle pulse on i_d produces o_press followed by o_release on consecutive cycles.
- Reset mid-hold: returns to IDLE with no o_release strobe.

Decomposition:
- Shared package btn_pkg:
  - typedef enum logic [1:0] btn_state_e {BTN_IDLE, BTN_PRESSED, BTN_HELD}.
  - Function clog2-based width helper for CNT_W.
- One natural sub-module, edge_det: registers a, outputs rise/fall strobes.
  - Synchronous reset preloads the register from the input.
  - Reusable for other debounced inputs.
- FSM and counter stay in btn_event_gen.

Test Plan:
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4, 40 ns clock.
1. i_d=0 through reset, deassert rst, then i_d=1 for 3 cycles, then 0 -> o_press high 1 cycle after first sampled 1; o_release 3 cycles later; no o_long; o_held high exactly 3 cycles.
2. i_d=1 held for 20 cycles -> o_press at cycle P, o_long at P+8, o_repeat at P+12 and P+16, o_release on drop; o_held high from P to release.
3. i_d=1 while rst=1, rst deasserted, i_d held 12 cycles -> no o_press/o_long/o_repeat; after i_d 0 then 1, normal o_press.
4. Release timed on the edge where o_long would fire (i_d=1 for exactly 8 cycles) -> o_release only, o_long never asserted.
5. rst pulsed 1 cycle while in HELD -> all outputs 0 next cycle, no o_release; subsequent press works normally.
6. REPEAT_EN=0, i_d held 30 cycles -> single o_long at P+8, no o_repeat, o_held stays 1 until release.
